freelist: RTL and testbench

FREELIST -- requirements
Module: freelist

---
 rtl/freelist.sv | 91 +++++++++
 tb/tb_freelist.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
// rtl/freelist.sv - physical register free list with in-order multi-lane allocation
package sys_defs;
    parameter int N                = 3;
    parameter int PHYS_REG_SZ_R10K = 64;
    parameter int ARCH_REG_SZ      = 32;
    localparam int PHYS_TAG_W      = $clog2(PHYS_REG_SZ_R10K);
    localparam int FREE_CNT_W      = $clog2(PHYS_REG_SZ_R10K + 1);
    typedef logic [PHYS_TAG_W-1:0] PHYS_TAG;
endpackage

module freelist
    import sys_defs::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N-1:0]                alloc_req,
    output logic [N-1:0]                alloc_valid,
    output PHYS_TAG                     alloc_tags [N],
    input  logic [PHYS_REG_SZ_R10K-1:0] free_mask,
    input  logic                        mispredict,
    input  logic [PHYS_REG_SZ_R10K-1:0] restore_mask,
    output logic [FREE_CNT_W-1:0]       free_count,
    output logic [PHYS_REG_SZ_R10K-1:0] avail_mask
);
    localparam logic [PHYS_REG_SZ_R10K-1:0] RESET_AVAIL =
        {{(PHYS_REG_SZ_R10K-ARCH_REG_SZ){1'b1}}, {ARCH_REG_SZ{1'b0}}};
    localparam logic [FREE_CNT_W-1:0] RESET_COUNT =
        FREE_CNT_W'(PHYS_REG_SZ_R10K - ARCH_REG_SZ);

    logic [PHYS_REG_SZ_R10K-1:0] avail;
    logic [FREE_CNT_W-1:0]       count;
    logic [PHYS_REG_SZ_R10K-1:0] remaining;
    logic [PHYS_REG_SZ_R10K-1:0] granted;
    logic [PHYS_REG_SZ_R10K-1:0] next_avail;
    logic [FREE_CNT_W-1:0]       next_count;
    logic                        found;

    // Each lane scans what lower lanes left behind; tag 0 is never offered.
    always_comb begin
        remaining    = avail;
        remaining[0] = 1'b0;
        granted      = '0;
        alloc_valid  = '0;
        found        = 1'b0;
        for (int i = 0; i < N; i++) begin
            alloc_tags[i] = '0;
        end
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                found = 1'b0;
                if (alloc_req[i]) begin
                    for (int t = 1; t < PHYS_REG_SZ_R10K; t++) begin
                        if (!found && remaining[t]) begin
                            found          = 1'b1;
                            alloc_valid[i] = 1'b1;
                            alloc_tags[i]  = PHYS_TAG'(t);
                            remaining[t]   = 1'b0;
                            granted[t]     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        if (mispredict) begin
            next_avail = restore_mask;
        end else begin
            next_avail = (avail & ~granted) | free_mask;
        end
        next_avail[0] = 1'b0;
        next_count    = '0;
        for (int t = 0; t < PHYS_REG_SZ_R10K; t++) begin
            next_count = next_count + FREE_CNT_W'(next_avail[t]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avail <= RESET_AVAIL;
            count <= RESET_COUNT;
        end else begin
            avail <= next_avail;
            count <= next_count;
        end
    end

    assign free_count = count;
    assign avail_mask = avail;
endmodule

// File: tb/tb_freelist.sv
// tb/tb_freelist.sv - directed self-checking bench for freelist
module tb_freelist;
    import sys_defs::*;

    logic                        clock;
    logic                        reset_n;
    logic [N-1:0]                alloc_req;
    logic [N-1:0]                alloc_valid;
    PHYS_TAG                     alloc_tags [N];
    logic [PHYS_REG_SZ_R10K-1:0] free_mask;
    logic                        mispredict;
    logic [PHYS_REG_SZ_R10K-1:0] restore_mask;
    logic [FREE_CNT_W-1:0]       free_count;
    logic [PHYS_REG_SZ_R10K-1:0] avail_mask;

    int checks = 0;
    int errors = 0;

    freelist dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tags   (alloc_tags),
        .free_mask    (free_mask),
        .mispredict   (mispredict),
        .restore_mask (restore_mask),
        .free_count   (free_count),
        .avail_mask   (avail_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change just after a falling edge; registered values are read there too.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        alloc_req    = '0;
        free_mask    = '0;
        mispredict   = 1'b0;
        restore_mask = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        alloc_req = 3'b111;
        free_mask = '0;
        mispredict = 1'b0;
        restore_mask = '0;
        @(negedge clock);
        #1;
        checks++;
        if (alloc_valid !== 3'b000) begin
            errors++; $display("FAIL reset_valid got %b exp 000", alloc_valid);
        end
        checks++;
        if (free_count !== 7'd32) begin
            errors++; $display("FAIL reset_count got %0d exp 32", free_count);
        end
        checks++;
        if (avail_mask !== 64'hFFFF_FFFF_0000_0000) begin
            errors++; $display("FAIL reset_avail got %h exp ffffffff00000000", avail_mask);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (alloc_valid !== 3'b111 || alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33 || alloc_tags[2] !== 6'd34) begin
            errors++;
            $display("FAIL first_grant got v=%b %0d %0d %0d exp v=111 32 33 34", alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        step();
        checks++;
        if (free_count !== 7'd29) begin
            errors++; $display("FAIL first_count got %0d exp 29", free_count);
        end
    endtask

    task automatic test_partial_req();
        do_reset();
        alloc_req = 3'b101;
        #1;
        checks++;
        if (alloc_valid !== 3'b101 || alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd0 || alloc_tags[2] !== 6'd33) begin
            errors++;
            $display("FAIL skip_lane got v=%b %0d %0d %0d exp v=101 32 0 33", alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        step();
        checks++;
        if (free_count !== 7'd30 || avail_mask !== 64'hFFFF_FFFC_0000_0000) begin
            errors++; $display("FAIL skip_lane_state got %0d %h exp 30 fffffffc00000000", free_count, avail_mask);
        end
    endtask

    task automatic test_drain();
        do_reset();
        alloc_req = 3'b111;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (free_count !== 7'd2 || avail_mask !== 64'hC000_0000_0000_0000) begin
            errors++; $display("FAIL drain_state got %0d %h exp 2 c000000000000000", free_count, avail_mask);
        end
        #1;
        checks++;
        if (alloc_valid !== 3'b011 || alloc_tags[0] !== 6'd62 || alloc_tags[1] !== 6'd63 || alloc_tags[2] !== 6'd0) begin
            errors++;
            $display("FAIL drain_partial got v=%b %0d %0d %0d exp v=011 62 63 0", alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        step();
        #1;
        checks++;
        if (free_count !== 7'd0 || alloc_valid !== 3'b000 || alloc_tags[0] !== 6'd0 || alloc_tags[1] !== 6'd0 || alloc_tags[2] !== 6'd0) begin
            errors++;
            $display("FAIL drain_empty got cnt=%0d v=%b %0d %0d %0d exp 0 000 0 0 0", free_count, alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
    endtask

    task automatic test_free();
        do_reset();
        alloc_req = 3'b111;
        for (int k = 0; k < 3; k++) step();
        alloc_req = 3'b000;
        free_mask = 64'h0000_00FF_0000_0000;
        step();
        checks++;
        if (free_count !== 7'd31 || avail_mask !== 64'hFFFF_FEFF_0000_0000) begin
            errors++; $display("FAIL free_setup got %0d %h exp 31 fffffeff00000000", free_count, avail_mask);
        end
        free_mask = 64'h0000_0100_0000_0001;
        alloc_req = 3'b111;
        #1;
        checks++;
        if (alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33 || alloc_tags[2] !== 6'd34) begin
            errors++;
            $display("FAIL free_not_visible got %0d %0d %0d exp 32 33 34", alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        alloc_req = 3'b000;
        #1;
        checks++;
        if (alloc_valid !== 3'b000) begin
            errors++; $display("FAIL no_req_valid got %b exp 000", alloc_valid);
        end
        step();
        checks++;
        if (free_count !== 7'd32 || avail_mask !== 64'hFFFF_FFFF_0000_0000) begin
            errors++; $display("FAIL free_result got %0d %h exp 32 ffffffff00000000", free_count, avail_mask);
        end
        free_mask = 64'h0004_0000_0000_0001;
        step();
        checks++;
        if (free_count !== 7'd32 || avail_mask[0] !== 1'b0) begin
            errors++; $display("FAIL double_free got %0d bit0=%b exp 32 0", free_count, avail_mask[0]);
        end
        free_mask = '0;
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_req    = 3'b111;
        mispredict   = 1'b1;
        restore_mask = 64'hFFFF_0000_0000_0001;
        free_mask    = 64'h0000_0000_0000_0400;
        #1;
        checks++;
        if (alloc_valid !== 3'b111 || alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33 || alloc_tags[2] !== 6'd34) begin
            errors++;
            $display("FAIL mp_grant got v=%b %0d %0d %0d exp v=111 32 33 34", alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        step();
        mispredict = 1'b0;
        free_mask  = '0;
        alloc_req  = 3'b000;
        checks++;
        if (avail_mask !== 64'hFFFF_0000_0000_0000 || free_count !== 7'd16) begin
            errors++; $display("FAIL mp_restore got %0d %h exp 16 ffff000000000000", free_count, avail_mask);
        end
        alloc_req = 3'b001;
        #1;
        checks++;
        if (alloc_tags[0] !== 6'd48) begin
            errors++; $display("FAIL mp_next_grant got %0d exp 48", alloc_tags[0]);
        end
        alloc_req = 3'b000;
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_req = 3'b111;
        for (int k = 0; k < 9; k++) step();
        checks++;
        if (free_count !== 7'd5) begin
            errors++; $display("FAIL async_setup got %0d exp 5", free_count);
        end
        mispredict   = 1'b1;
        restore_mask = '0;
        free_mask    = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (free_count !== 7'd32 || avail_mask !== 64'hFFFF_FFFF_0000_0000) begin
            errors++; $display("FAIL async_reset got %0d %h exp 32 ffffffff00000000", free_count, avail_mask);
        end
        checks++;
        if (alloc_valid !== 3'b000 || alloc_tags[0] !== 6'd0 || alloc_tags[1] !== 6'd0 || alloc_tags[2] !== 6'd0) begin
            errors++; $display("FAIL async_outputs got v=%b %0d %0d %0d exp 000 0 0 0", alloc_valid, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
        @(negedge clock);
        mispredict = 1'b0;
        free_mask  = '0;
        reset_n    = 1'b1;
        step();
        checks++;
        if (free_count !== 7'd29 || avail_mask !== 64'hFFFF_FFF8_0000_0000) begin
            errors++; $display("FAIL post_reset_edge got %0d %h exp 29 fffffff800000000", free_count, avail_mask);
        end
    endtask

    initial begin
        test_reset();
        test_partial_req();
        test_drain();
        test_free();
        test_mispredict();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
